// File: rtl/regfile_wb_pkg.sv
// Shared widths and the queued writeback entry type for the register file
// writeback queue.
package regfile_wb_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Producer handshake, register file write port and hazard query signals
// of the writeback queue.
interface regfile_writeback_queue_if
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) ();

   logic                     wb_valid;
   logic                     wb_ready;
   logic [AW-1:0]            wb_rd;
   logic [XLEN-1:0]          wb_data;
   logic                     drain_en;
   logic                     rf_we;
   logic [AW-1:0]            rf_waddr;
   logic [XLEN-1:0]          rf_wdata;
   logic [AW-1:0]            rs1;
   logic [AW-1:0]            rs2;
   logic                     rs1_busy;
   logic                     rs2_busy;
   logic [XLEN-1:0]          rs1_fwd_data;
   logic [XLEN-1:0]          rs2_fwd_data;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output wb_valid, wb_rd, wb_data, drain_en, rs1, rs2,
      input  wb_ready, rf_we, rf_waddr, rf_wdata, rs1_busy, rs2_busy,
             rs1_fwd_data, rs2_fwd_data, count
   );

   modport slave (
      input  wb_valid, wb_rd, wb_data, drain_en, rs1, rs2,
      output wb_ready, rf_we, rf_waddr, rf_wdata, rs1_busy, rs2_busy,
             rs1_fwd_data, rs2_fwd_data, count
   );

endinterface

// File: rtl/wb_match_youngest.sv
// Age-ordered search of the queue for the youngest valid entry writing a
// given register; used once per decode read port.
module wb_match_youngest
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  wb_entry_t                  entries_i [DEPTH],
   input  logic [DEPTH-1:0]           valid_i,
   input  logic [$clog2(DEPTH)-1:0]   head_i,
   input  logic [AW-1:0]              addr_i,
   output logic                       hit_o,
   output logic [XLEN-1:0]            data_o
);

   localparam int unsigned IW = $clog2(DEPTH);

   // Walk oldest to youngest from head so the last match (nearest tail-1) wins;
   // valid entries are contiguous from head, so this equals a search from tail-1.
   always_comb begin
      logic [IW-1:0] idx;
      hit_o  = 1'b0;
      data_o = '0;
      idx    = head_i;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_i + IW'(i);
         if (addr_i != '0 && valid_i[idx] && entries_i[idx].rd == addr_i) begin
            hit_o  = 1'b1;
            data_o = entries_i[idx].data;
         end
      end
   end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the register file write port, with
// per-source-register pending and forwarding lookup.
module regfile_writeback_queue
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input logic                      clk,
   input logic                      rst,
   regfile_writeback_queue_if.slave bus
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;

   wb_entry_t        entries_q [DEPTH];
   wb_entry_t        entries_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [IW-1:0]    head_q, head_d;
   logic [IW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   logic ready, accept, push, pop;

   assign ready  = (count_q != CW'(DEPTH));
   assign accept = bus.wb_valid && ready;
   // Writes to x0 complete the handshake but are dropped.
   assign push   = accept && (bus.wb_rd != '0);
   assign pop    = bus.drain_en && (count_q != '0);

   always_comb begin
      entries_d = entries_q;
      valid_d   = valid_q;
      head_d    = head_q;
      tail_d    = tail_q;
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (push) begin
         entries_d[tail_q] = '{rd: bus.wb_rd, data: bus.wb_data};
         valid_d[tail_q]   = 1'b1;
         tail_d            = tail_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

   assign bus.wb_ready = ready;
   assign bus.rf_we    = pop;
   assign bus.rf_waddr = entries_q[head_q].rd;
   assign bus.rf_wdata = entries_q[head_q].data;
   assign bus.count    = count_q;

   wb_match_youngest #(.DEPTH(DEPTH)) u_match_rs1 (
      .entries_i (entries_q),
      .valid_i   (valid_q),
      .head_i    (head_q),
      .addr_i    (bus.rs1),
      .hit_o     (bus.rs1_busy),
      .data_o    (bus.rs1_fwd_data)
   );

   wb_match_youngest #(.DEPTH(DEPTH)) u_match_rs2 (
      .entries_i (entries_q),
      .valid_i   (valid_q),
      .head_i    (head_q),
      .addr_i    (bus.rs2),
      .hit_o     (bus.rs2_busy),
      .data_o    (bus.rs2_fwd_data)
   );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomized and directed bench for regfile_writeback_queue against a
// queue-based reference model.
module tb_regfile_writeback_queue;
   import regfile_wb_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

   regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   wb_entry_t mq[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] data,
                        input logic drain, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      bus.wb_valid = v;
      bus.wb_rd    = rd;
      bus.wb_data  = data;
      bus.drain_en = drain;
      bus.rs1      = r1;
      bus.rs2      = r2;
   endtask

   task automatic lookup(input logic [AW-1:0] rs, output logic hit, output logic [XLEN-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (rs != '0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == rs) begin
               hit = 1'b1;
               d   = mq[i].data;
               break;
            end
         end
      end
   endtask

   task automatic check_outputs();
      int n;
      logic h1, h2, exp_we;
      logic [XLEN-1:0] d1, d2;
      n      = mq.size();
      exp_we = bus.drain_en && (n != 0);
      check_eq("count", 64'(bus.count), 64'(n));
      check_eq("wb_ready", 64'(bus.wb_ready), 64'(n != DEPTH));
      check_eq("rf_we", 64'(bus.rf_we), 64'(exp_we));
      if (exp_we) begin
         check_eq("rf_waddr", 64'(bus.rf_waddr), 64'(mq[0].rd));
         check_eq("rf_wdata", 64'(bus.rf_wdata), 64'(mq[0].data));
      end
      lookup(bus.rs1, h1, d1);
      lookup(bus.rs2, h2, d2);
      check_eq("rs1_busy", 64'(bus.rs1_busy), 64'(h1));
      check_eq("rs2_busy", 64'(bus.rs2_busy), 64'(h2));
      check_eq("rs1_fwd", 64'(bus.rs1_fwd_data), 64'(d1));
      check_eq("rs2_fwd", 64'(bus.rs2_fwd_data), 64'(d2));
   endtask

   task automatic model_edge();
      logic rdy;
      rdy = (mq.size() != DEPTH);
      if (bus.drain_en && mq.size() != 0) void'(mq.pop_front());
      if (bus.wb_valid && rdy && bus.wb_rd != '0)
         mq.push_back('{rd: bus.wb_rd, data: bus.wb_data});
   endtask

   task automatic cycle(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] data,
                        input logic drain, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      drive(v, rd, data, drain, r1, r2);
      @(negedge clk);
      check_outputs();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned bias;
      drive(0, 0, 0, 0, 0, 0);
      #1 rst = 1'b1;
      #11 rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset state, then single push with immediate drain.
      cycle(0, 0, 32'h0, 0, 0, 0);
      cycle(1, 5, 32'hDEADBEEF, 1, 0, 0);
      cycle(0, 0, 32'h0, 1, 5, 0);
      cycle(0, 0, 32'h0, 1, 5, 0);

      // Fill to full with a stalled fifth push, then drain in order.
      for (int i = 1; i <= 5; i++) cycle(1, AW'(i), 32'h100 + i, 0, 3, 4);
      for (int i = 0; i < 5; i++) cycle(0, 0, 32'h0, 1, 2, 4);

      // Same rd twice: youngest forwards.
      cycle(1, 7, 32'h11, 0, 7, 0);
      cycle(1, 7, 32'h22, 0, 7, 0);
      cycle(0, 0, 32'h0, 0, 7, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 1, 7, 7);

      // x0 write is accepted but never committed.
      cycle(1, 0, 32'hFF, 1, 0, 0);
      for (int i = 0; i < 2; i++) cycle(0, 0, 32'h0, 1, 0, 0);

      // Asynchronous reset with three entries held.
      cycle(1, 3, 32'h33, 0, 0, 0);
      cycle(1, 4, 32'h44, 0, 0, 0);
      cycle(1, 6, 32'h66, 0, 0, 0);
      drive(0, 0, 0, 1, 4, 6);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_rf_we", 64'(bus.rf_we), 64'd0);
      check_eq("rst_count", 64'(bus.count), 64'd0);
      check_eq("rst_ready", 64'(bus.wb_ready), 64'd1);
      check_eq("rst_rs1_busy", 64'(bus.rs1_busy), 64'd0);
      mq.delete();
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) cycle(0, 0, 32'h0, 1, 4, 6);

      // Random traffic with shifting drain pressure so the queue hits full and empty.
      for (int blk = 0; blk < 6; blk++) begin
         bias = $urandom_range(1, 3);
         for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) < bias, AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
